mul_share_sched: RTL and testbench

- Round-robin scheduler that time-shares one pipelined 16x16 signed DSP multiplier (LATENCY ce-gated register stages, 16-bit truncated product) among N_REQ requesters in the BGD datapath.
- Accepts at most one operand pair per cycle and drives the multiplier's ce/din0/din1.
- Carries requester ID and valid through a tag pipeline aligned with the multiplier, and returns each product with its ID on one shared result port.
- Stalls the whole multiplier pipeline on result backpressure.

---
 rtl/mul_share_pkg.sv | 15 +
 rtl/mul_share_rr_pick.sv | 37 +++
 rtl/mul_share_sched.sv | 116 +++++++++++
 tb/tb_mul_share_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared constants and helpers for the shared-multiplier scheduler.
// Imported by mul_share_rr_pick and mul_share_sched.
package mul_share_pkg;

    localparam int DATA_W  = 16;
    localparam int MAX_REQ = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mul_share_rr_pick.sv
// Rotate-priority picker: first set bit at or above ptr_i, wrapping.
// Produces a one-hot grant, its binary index and an any-grant flag.
module mul_share_rr_pick
    import mul_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    int   pos;
    logic found;

    // Scan N_REQ positions starting at ptr_i, keep the first requester.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = ID_W'(pos);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mul_share_sched.sv
// Time-shares one pipelined signed 16x16 multiplier among N_REQ requesters.
// MUL_SHARE_SCHED_STRICT_PRIO_EN: fixed priority (index 0 wins), no rr pointer.
module mul_share_sched
    import mul_share_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 3,
    parameter int ID_W    = clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [DATA_W*N_REQ-1:0]   req_a,
    input  logic [DATA_W*N_REQ-1:0]   req_b,
    output logic                      mul_ce,
    output logic [DATA_W-1:0]         mul_din0,
    output logic [DATA_W-1:0]         mul_din1,
    input  logic [DATA_W-1:0]         mul_dout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    output logic                      busy
);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [ID_W-1:0]    id_q [LATENCY];
    logic [ID_W-1:0]    id_d [LATENCY];
    logic [N_REQ-1:0]   gnt;
    logic [ID_W-1:0]    idx;
    logic [ID_W-1:0]    ptr;
    logic               any;
    logic               stall;

    assign stall  = vld_q[LATENCY-1] & ~out_ready;
    assign mul_ce = ~stall & ~reset;

    mul_share_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i (req_valid & {N_REQ{mul_ce}}),
        .ptr_i (ptr),
        .gnt_o (gnt),
        .idx_o (idx),
        .any_o (any)
    );

    assign req_ready = gnt;

`ifdef MUL_SHARE_SCHED_STRICT_PRIO_EN
    assign ptr = '0;
`else
    logic [ID_W-1:0] rr_q, rr_d;

    // Advance the pointer just past the requester that transferred.
    always_comb begin
        rr_d = rr_q;
        if (any) begin
            rr_d = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + ID_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) rr_q <= '0;
        else       rr_q <= rr_d;
    end

    assign ptr = rr_q;
`endif

    // Route the granted requester's operands; zero when idle.
    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                mul_din0 = req_a[i*DATA_W +: DATA_W];
                mul_din1 = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Tag pipeline shifts in lockstep with the multiplier's ce.
    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        if (mul_ce) begin
            vld_d[0] = any;
            id_d[0]  = idx;
            for (int s = 1; s < LATENCY; s++) begin
                vld_d[s] = vld_q[s-1];
                id_d[s]  = id_q[s-1];
            end
        end
    end

    // Tag pipeline registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            id_q  <= '{default: '0};
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign out_valid = vld_q[LATENCY-1] & ~reset;
    assign out_id    = reset ? '0 : id_q[LATENCY-1];
    assign out_data  = mul_dout;
    assign busy      = (|vld_q) & ~reset;

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched with a ce-gated multiplier stand-in.
// Honors MUL_SHARE_SCHED_STRICT_PRIO_EN for the arbitration section.
module tb_mul_share_sched;

    localparam int N  = 4;
    localparam int L  = 3;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic          mul_ce;
    logic [15:0]   mul_din0;
    logic [15:0]   mul_din1;
    logic [15:0]   mul_dout;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic [IW-1:0] out_id;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] mp [L];
    logic [15:0] fair_prod [4];

    always #5 clk = ~clk;

    mul_share_sched #(
        .N_REQ   (N),
        .LATENCY (L),
        .ID_W    (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (mul_ce) begin
            mp[0] <= 16'($signed(mul_din0) * $signed(mul_din1));
            for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
        end
    end
    assign mul_dout = mp[L-1];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int i, input logic [15:0] a,
                       input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b1;

        // Reset state
        settle();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_ce", 32'(mul_ce), 32'h0);
        chk("rst_ovalid", 32'(out_valid), 32'h0);
        chk("rst_oid", 32'(out_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        cyc();
        reset     = 1'b0;
        req_valid = '0;

        // Single op: req 1, -3 * 7
        put(1, 16'hFFFD, 16'h0007);
        req_valid = 4'b0010;
        settle();
        chk("s_gnt", 32'(req_ready), 32'h2);
        chk("s_din0", 32'(mul_din0), 32'hFFFD);
        chk("s_din1", 32'(mul_din1), 32'h0007);
        chk("s_busy0", 32'(busy), 32'h0);
        cyc();
        req_valid = '0;
        settle();
        chk("s_din_idle", 32'(mul_din0), 32'h0);
        chk("s_busy1", 32'(busy), 32'h1);
        chk("s_ov1", 32'(out_valid), 32'h0);
        cyc();
        settle();
        chk("s_busy2", 32'(busy), 32'h1);
        chk("s_ov2", 32'(out_valid), 32'h0);
        cyc();
        settle();
        chk("s_ov3", 32'(out_valid), 32'h1);
        chk("s_data", 32'(out_data), 32'hFFEB);
        chk("s_id", 32'(out_id), 32'h1);
        chk("s_busy3", 32'(busy), 32'h1);
        cyc();
        settle();
        chk("s_ov4", 32'(out_valid), 32'h0);
        chk("s_busy4", 32'(busy), 32'h0);
        cyc();

        // Overflow wrap: 300 * 300 on req 2
        put(2, 16'd300, 16'd300);
        req_valid = 4'b0100;
        settle();
        chk("w_gnt", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        settle();
        chk("w_ov", 32'(out_valid), 32'h1);
        chk("w_data", 32'(out_data), 32'd24464);
        chk("w_id", 32'(out_id), 32'h2);
        cyc();

        // Arbitration from a fresh reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
`ifdef MUL_SHARE_SCHED_STRICT_PRIO_EN
        put(0, 16'd2, 16'd3);
        put(2, 16'd7, 16'hFFF8);
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 4) ? 4'b0101 : 4'b0100;
            settle();
            chk("p_gnt", 32'(req_ready), (k < 4) ? 32'h1 : 32'h4);
            cyc();
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) cyc();
`else
        put(0, 16'd2, 16'd3);
        put(1, 16'hFFFC, 16'd5);
        put(2, 16'd7, 16'hFFF8);
        put(3, 16'd100, 16'hFFFF);
        fair_prod[0] = 16'h0006;
        fair_prod[1] = 16'hFFEC;
        fair_prod[2] = 16'hFFC8;
        fair_prod[3] = 16'hFF9C;
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            settle();
            if (k < 8)
                chk("f_gnt", 32'(req_ready), 32'h1 << (k % 4));
            if (k >= 3 && k < 11) begin
                chk("f_ov", 32'(out_valid), 32'h1);
                chk("f_id", 32'(out_id), 32'((k - 3) % 4));
                chk("f_data", 32'(out_data), 32'(fair_prod[(k - 3) % 4]));
            end else begin
                chk("f_ov_idle", 32'(out_valid), 32'h0);
            end
            cyc();
        end
`endif

        // Backpressure: three ops, then out_ready low for 5 cycles
        put(0, 16'd5, 16'hFFFE);
        put(1, 16'hFF9C, 16'hFF9C);
        put(2, 16'd1000, 16'd70);
        put(3, 16'd1, 16'd1);
        req_valid = 4'b0001;
        settle();
        chk("b_gnt0", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0010;
        settle();
        chk("b_gnt1", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 4'b0100;
        settle();
        chk("b_gnt2", 32'(req_ready), 32'h4);
        cyc();
        req_valid = 4'b1000;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("b_ce", 32'(mul_ce), 32'h0);
            chk("b_ready", 32'(req_ready), 32'h0);
            chk("b_ov", 32'(out_valid), 32'h1);
            chk("b_data", 32'(out_data), 32'hFFF6);
            chk("b_id", 32'(out_id), 32'h0);
            cyc();
        end
        req_valid = '0;
        out_ready = 1'b1;
        settle();
        chk("b_rel_ce", 32'(mul_ce), 32'h1);
        chk("b_r0_ov", 32'(out_valid), 32'h1);
        chk("b_r0_data", 32'(out_data), 32'hFFF6);
        chk("b_r0_id", 32'(out_id), 32'h0);
        cyc();
        settle();
        chk("b_r1_ov", 32'(out_valid), 32'h1);
        chk("b_r1_data", 32'(out_data), 32'h2710);
        chk("b_r1_id", 32'(out_id), 32'h1);
        cyc();
        settle();
        chk("b_r2_ov", 32'(out_valid), 32'h1);
        chk("b_r2_data", 32'(out_data), 32'h1170);
        chk("b_r2_id", 32'(out_id), 32'h2);
        cyc();
        settle();
        chk("b_end_ov", 32'(out_valid), 32'h0);
        chk("b_end_busy", 32'(busy), 32'h0);
        cyc();

        // Reset one cycle before the first result is due
        put(1, 16'd9, 16'd9);
        put(2, 16'd3, 16'd3);
        req_valid = 4'b0010;
        settle();
        chk("m_gnt0", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 4'b0100;
        settle();
        chk("m_gnt1", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        reset     = 1'b1;
        settle();
        chk("m_rst_ov", 32'(out_valid), 32'h0);
        chk("m_rst_busy", 32'(busy), 32'h0);
        chk("m_rst_ce", 32'(mul_ce), 32'h0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("m_ov_drop", 32'(out_valid), 32'h0);
            chk("m_busy_drop", 32'(busy), 32'h0);
            cyc();
        end
        put(1, 16'hFFFF, 16'hFFFF);
        put(3, 16'd4, 16'd4);
        req_valid = 4'b1010;
        settle();
        chk("m_gnt_after", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        settle();
        chk("m_n1_ov", 32'(out_valid), 32'h0);
        cyc();
        settle();
        chk("m_n2_ov", 32'(out_valid), 32'h0);
        cyc();
        settle();
        chk("m_n3_ov", 32'(out_valid), 32'h1);
        chk("m_n3_data", 32'(out_data), 32'h0001);
        chk("m_n3_id", 32'(out_id), 32'h1);
        cyc();
        settle();
        chk("m_n4_ov", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
